// File: rtl/dmem_port_arbiter.sv
// Arbitrates a load port and a store-buffer drain port onto a single data-memory
// port with one transaction outstanding, store anti-starvation and load flush/kill.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_req,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    input  logic [DATA_WIDTH/8-1:0] ld_rmask,
    output logic                    ld_gnt,
    output logic                    ld_rvalid,
    output logic [DATA_WIDTH-1:0]   ld_rdata,
    input  logic                    st_req,
    input  logic [ADDR_WIDTH-1:0]   st_addr,
    input  logic [DATA_WIDTH-1:0]   st_wdata,
    input  logic [DATA_WIDTH/8-1:0] st_wmask,
    input  logic                    st_urgent,
    output logic                    st_gnt,
    output logic                    st_done,
    input  logic                    flush,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   dmem_addr,
    output logic [DATA_WIDTH/8-1:0] dmem_rmask,
    output logic [DATA_WIDTH/8-1:0] dmem_wmask,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata,
    input  logic                    dmem_resp
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       starve_cnt, starve_nxt;
    logic                   kill, kill_nxt;
    logic                   zero_done, zero_done_nxt;
    logic [ADDR_WIDTH-1:0]  addr_nxt;
    logic [MASK_W-1:0]      rmask_nxt, wmask_nxt;
    logic [DATA_WIDTH-1:0]  wdata_nxt;
    logic                   starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        kill_nxt      = kill;
        zero_done_nxt = 1'b0;
        addr_nxt      = dmem_addr;
        rmask_nxt     = dmem_rmask;
        wmask_nxt     = dmem_wmask;
        wdata_nxt     = dmem_wdata;
        ld_gnt        = 1'b0;
        st_gnt        = 1'b0;
        ld_rvalid     = 1'b0;
        ld_rdata      = '0;
        st_done       = zero_done;

        case (state)
            IDLE: begin
                // Grants are gated by rst so they stay low while reset is held.
                if (rst) begin
                    if (st_req && (st_urgent || starved))
                        st_gnt = 1'b1;
                    else if (ld_req && !flush)
                        ld_gnt = 1'b1;
                    else if (st_req)
                        st_gnt = 1'b1;
                end

                if (ld_gnt) begin
                    state_nxt = LOAD;
                    addr_nxt  = ld_addr;
                    rmask_nxt = ld_rmask;
                    wmask_nxt = '0;
                    wdata_nxt = '0;
                    if (st_req && !starved)
                        starve_nxt = starve_cnt + 1'b1;
                end

                if (st_gnt) begin
                    starve_nxt = '0;
                    if (st_wmask != '0) begin
                        state_nxt = STORE;
                        addr_nxt  = st_addr;
                        wdata_nxt = st_wdata;
                        wmask_nxt = st_wmask;
                        rmask_nxt = '0;
                    end else begin
                        // Empty-mask store retires without touching memory.
                        zero_done_nxt = 1'b1;
                    end
                end
            end

            LOAD: begin
                if (flush)
                    kill_nxt = 1'b1;
                if (dmem_resp) begin
                    if (!kill && !flush) begin
                        ld_rvalid = 1'b1;
                        ld_rdata  = dmem_rdata;
                    end
                    state_nxt = IDLE;
                    kill_nxt  = 1'b0;
                    addr_nxt  = '0;
                    rmask_nxt = '0;
                    wmask_nxt = '0;
                    wdata_nxt = '0;
                end
            end

            STORE: begin
                if (dmem_resp) begin
                    st_done   = 1'b1;
                    state_nxt = IDLE;
                    addr_nxt  = '0;
                    rmask_nxt = '0;
                    wmask_nxt = '0;
                    wdata_nxt = '0;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            kill       <= 1'b0;
            zero_done  <= 1'b0;
            dmem_addr  <= '0;
            dmem_rmask <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            kill       <= kill_nxt;
            zero_done  <= zero_done_nxt;
            dmem_addr  <= addr_nxt;
            dmem_rmask <= rmask_nxt;
            dmem_wmask <= wmask_nxt;
            dmem_wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared each cycle against a transaction-level model.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req, ld_gnt, ld_rvalid;
    logic [AW-1:0] ld_addr;
    logic [MW-1:0] ld_rmask;
    logic [DW-1:0] ld_rdata;
    logic          st_req, st_urgent, st_gnt, st_done;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_wdata;
    logic [MW-1:0] st_wmask;
    logic          flush, busy;
    logic [AW-1:0] dmem_addr;
    logic [MW-1:0] dmem_rmask, dmem_wmask;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          dmem_resp;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_wmask(st_wmask),
        .st_urgent(st_urgent), .st_gnt(st_gnt), .st_done(st_done),
        .flush(flush), .busy(busy),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    // Values to present during the next cycle.
    logic          n_rst, n_ld_req, n_st_req, n_urgent, n_flush, n_resp;
    logic [AW-1:0] n_ld_addr, n_st_addr;
    logic [MW-1:0] n_ld_rmask, n_st_wmask;
    logic [DW-1:0] n_st_wdata, n_rdata;

    // Reference model: which transaction is outstanding (0 none, 1 load, 2 store).
    int            m_pend;
    int            m_starve;
    bit            m_kill, m_zdone;
    logic [AW-1:0] m_addr;
    logic [MW-1:0] m_rmask, m_wmask;
    logic [DW-1:0] m_wdata;
    bit            g_ld, g_st;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_starve = 0; m_kill = 0; m_zdone = 0;
        m_addr = '0; m_rmask = '0; m_wmask = '0; m_wdata = '0;
    endtask

    task automatic cycle();
        bit            idle, e_ldg, e_stg, e_rv, e_sd, e_busy, load_wins;
        logic [DW-1:0] e_rdata;
        @(posedge clk);
        #1;
        rst = n_rst; ld_req = n_ld_req; ld_addr = n_ld_addr; ld_rmask = n_ld_rmask;
        st_req = n_st_req; st_addr = n_st_addr; st_wdata = n_st_wdata; st_wmask = n_st_wmask;
        st_urgent = n_urgent; flush = n_flush; dmem_resp = n_resp; dmem_rdata = n_rdata;
        #4;
        if (!rst) begin
            model_reset();
            e_ldg = 0; e_stg = 0; e_rv = 0; e_sd = 0; e_busy = 0; e_rdata = '0;
        end else begin
            idle      = (m_pend == 0);
            load_wins = ld_req && !flush;
            e_stg = idle && st_req && (st_urgent || m_starve == SL || !load_wins);
            e_ldg = idle && !e_stg && load_wins;
            e_rv  = (m_pend == 1) && dmem_resp && !m_kill && !flush;
            e_rdata = e_rv ? dmem_rdata : '0;
            e_sd  = m_zdone || (m_pend == 2 && dmem_resp);
            e_busy = !idle;
        end
        chk("ctl{ldg,stg,rv,sd,busy}", {ld_gnt, st_gnt, ld_rvalid, st_done, busy},
            {e_ldg, e_stg, e_rv, e_sd, e_busy});
        chk("ld_rdata", ld_rdata, e_rdata);
        chk("dmem_addr", dmem_addr, m_addr);
        chk("dmem_rmask", dmem_rmask, m_rmask);
        chk("dmem_wmask", dmem_wmask, m_wmask);
        chk("dmem_wdata", dmem_wdata, m_wdata);
        g_ld = e_ldg; g_st = e_stg;
        if (rst) begin
            m_zdone = e_stg && (st_wmask == '0);
            if (m_pend == 1 && flush) m_kill = 1;
            if (m_pend != 0 && dmem_resp) begin
                m_pend = 0; m_kill = 0;
                m_addr = '0; m_rmask = '0; m_wmask = '0; m_wdata = '0;
            end
            if (e_ldg) begin
                m_pend = 1; m_addr = ld_addr; m_rmask = ld_rmask; m_wmask = '0; m_wdata = '0;
                if (st_req) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            end
            if (e_stg) begin
                m_starve = 0;
                if (st_wmask != '0) begin
                    m_pend = 2; m_addr = st_addr; m_wdata = st_wdata; m_wmask = st_wmask; m_rmask = '0;
                end
            end
        end
    endtask

    task automatic quiet_inputs();
        n_rst = 1; n_ld_req = 0; n_st_req = 0; n_urgent = 0; n_flush = 0; n_resp = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 0; ld_req = 0; ld_addr = '0; ld_rmask = '0; st_req = 0; st_addr = '0;
        st_wdata = '0; st_wmask = '0; st_urgent = 0; flush = 0; dmem_resp = 0; dmem_rdata = '0;
        n_ld_addr = '0; n_ld_rmask = '0; n_st_addr = '0; n_st_wdata = '0; n_st_wmask = '0;
        n_rdata = '0;
        quiet_inputs();
        n_rst = 0; n_ld_req = 1; n_st_req = 1; n_st_wmask = 4'hF;
        model_reset();
        cycle(); cycle();
        chk("rst_grants", {ld_gnt, st_gnt}, 2'b00);
        quiet_inputs();
        cycle();

        // Single load, response three cycles after the grant.
        n_ld_req = 1; n_ld_addr = 32'h100; n_ld_rmask = 4'hF;
        cycle(); chk("t24_gnt", ld_gnt, 1'b1);
        n_ld_req = 0;
        cycle(); chk("t24_rmask", dmem_rmask, 4'hF); chk("t24_addr", dmem_addr, 32'h100);
        cycle();
        n_resp = 1; n_rdata = 32'hDEADBEEF;
        cycle(); chk("t24_rvalid", ld_rvalid, 1'b1); chk("t24_rdata", ld_rdata, 32'hDEADBEEF);
        n_resp = 0;
        cycle(); chk("t24_idle", busy, 1'b0);

        // Both requesting, no urgency: eight loads then one store.
        n_ld_req = 1; n_ld_addr = 32'h140; n_ld_rmask = 4'h3;
        n_st_req = 1; n_st_addr = 32'h180; n_st_wdata = 32'h11223344; n_st_wmask = 4'hC;
        for (int i = 0; i < 27; i++) begin
            n_resp = 0;
            cycle();
            chk("t25_seq", {ld_gnt, st_gnt}, (i % 9 == 8) ? 2'b01 : 2'b10);
            n_resp = 1;
            cycle();
        end
        quiet_inputs();
        cycle();

        // Urgent store beats a simultaneous load.
        n_ld_req = 1; n_st_req = 1; n_urgent = 1;
        n_st_addr = 32'h200; n_st_wdata = 32'hCAFEF00D; n_st_wmask = 4'h5;
        cycle(); chk("t26_gnt", {ld_gnt, st_gnt}, 2'b01);
        quiet_inputs();
        cycle(); chk("t26_wmask", dmem_wmask, 4'h5); chk("t26_wdata", dmem_wdata, 32'hCAFEF00D);
        n_resp = 1;
        cycle(); chk("t26_done", st_done, 1'b1);
        n_resp = 0;
        cycle();

        // Flush after a load grant kills the returned data.
        n_ld_req = 1; n_ld_addr = 32'h300; n_ld_rmask = 4'h6;
        cycle();
        n_ld_req = 0; n_flush = 1;
        cycle(); chk("t27_rmask_a", dmem_rmask, 4'h6);
        n_flush = 0;
        cycle(); chk("t27_rmask_b", dmem_rmask, 4'h6);
        n_resp = 1; n_rdata = 32'h12345678;
        cycle(); chk("t27_rvalid", ld_rvalid, 1'b0); chk("t27_rdata", ld_rdata, 32'h0);
        n_resp = 0;
        cycle(); chk("t27_idle", busy, 1'b0);

        // Empty-mask store completes with no memory activity.
        n_st_req = 1; n_st_wmask = 4'h0; n_st_addr = 32'h400;
        cycle(); chk("t28_gnt", st_gnt, 1'b1);
        n_st_req = 0;
        cycle(); chk("t28_done", st_done, 1'b1); chk("t28_busy", busy, 1'b0);
        chk("t28_wmask", dmem_wmask, 4'h0);
        cycle();

        // Reset in the middle of a store abandons it.
        n_st_req = 1; n_st_wmask = 4'hF; n_st_addr = 32'h500; n_st_wdata = 32'hA5A5A5A5;
        cycle();
        n_st_req = 0;
        cycle(); chk("t29_busy_before", busy, 1'b1);
        n_rst = 0;
        cycle(); chk("t29_wmask", dmem_wmask, 4'h0); chk("t29_busy", busy, 1'b0);
        n_rst = 1; n_resp = 1;
        cycle(); chk("t29_no_done", st_done, 1'b0);
        quiet_inputs();
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (g_ld || !n_ld_req) begin
                n_ld_req = 1'($urandom_range(0, 1));
                n_ld_addr = $urandom;
                n_ld_rmask = 4'($urandom_range(0, 15));
            end
            if (g_st || !n_st_req) begin
                n_st_req = 1'($urandom_range(0, 1));
                n_st_addr = $urandom;
                n_st_wdata = $urandom;
                n_st_wmask = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            n_urgent = ($urandom_range(0, 5) == 0);
            n_flush  = ($urandom_range(0, 7) == 0);
            n_resp   = (m_pend != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            n_rdata  = $urandom;
            n_rst    = ($urandom_range(0, 399) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; mask width is DATA_WIDTH/8.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, maximum consecutive load grants while a store waits.
REQ-004 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge
 rst  in  1  asynchronous, active-low reset
 ld_req  in  1  load request, held until ld_gnt
 ld_addr  in  ADDR_WIDTH  load address
 ld_rmask  in  DATA_WIDTH/8  load byte mask
 ld_gnt  out  1  load accepted this cycle
 ld_rvalid  out  1  load data valid
 ld_rdata  out  DATA_WIDTH  load data
 st_req  in  1  store-buffer drain request, held until st_gnt
 st_addr  in  ADDR_WIDTH  store address
 st_wdata  in  DATA_WIDTH  store data
 st_wmask  in  DATA_WIDTH/8  store byte mask
 st_urgent  in  1  store buffer nearly full
 st_gnt  out  1  store accepted this cycle
 st_done  out  1  store write completed
 flush  in  1  squash outstanding/pending loads
 busy  out  1  transaction in flight
 dmem_addr  out  ADDR_WIDTH  memory address
 dmem_rmask  out  DATA_WIDTH/8  memory read mask
 dmem_wmask  out  DATA_WIDTH/8  memory write mask
 dmem_wdata  out  DATA_WIDTH  memory write data
 dmem_rdata  in  DATA_WIDTH  memory read data
 dmem_resp  in  1  memory response, one cycle

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, STORE; at most one dmem transaction outstanding.
REQ-006 SHALL, in IDLE, select per cycle: store if st_req && (st_urgent || starve_cnt==STARVE_LIMIT); else load if ld_req && !flush; else store if st_req; else none.
REQ-007 SHALL assert ld_gnt/st_gnt combinationally only in IDLE for the selected requester, mutually exclusive, one cycle each.
REQ-008 SHALL, on a load grant, register ld_addr/ld_rmask onto dmem_addr/dmem_rmask with dmem_wmask=0, dmem_wdata=0, and enter LOAD next cycle.
REQ-009 SHALL, on a store grant with st_wmask!=0, register st_addr/st_wdata/st_wmask onto dmem outputs with dmem_rmask=0 and enter STORE.
REQ-010 SHALL, on a store grant with st_wmask==0, pulse st_done the following cycle, issue no dmem transaction, remain IDLE.
REQ-011 SHALL hold all dmem outputs stable in LOAD/STORE until the dmem_resp cycle; dmem_rmask and dmem_wmask SHALL both be 0 in IDLE.
REQ-012 SHALL, in LOAD with dmem_resp=1, drive ld_rvalid=1 and ld_rdata=dmem_rdata combinationally that cycle (unless killed), clear dmem outputs and return to IDLE.
REQ-013 SHALL, in STORE with dmem_resp=1, drive st_done=1 combinationally that cycle, clear dmem outputs and return to IDLE.
REQ-014 SHALL never grant in the dmem_resp cycle; next grant is earliest the cycle after (grant N, request visible N+1, resp M, next grant M+1).
REQ-015 SHALL ignore dmem_resp while IDLE.
REQ-016 SHALL keep starve_cnt, width $clog2(STARVE_LIMIT+1): +1 (saturating at STARVE_LIMIT) on each load grant while st_req=1; cleared on any store grant.
REQ-017 SHALL, on flush in LOAD (including the resp cycle), set a kill flag; the matching dmem_resp completes the transaction with ld_rvalid=0; kill clears on leaving LOAD.
REQ-018 SHALL, on flush in IDLE, block load grants that cycle; store grants proceed.
REQ-019 SHALL never affect STORE transactions on flush.
REQ-020 SHALL drive busy=1 exactly when state is LOAD or STORE.
REQ-021 SHALL drive ld_rdata=0 whenever ld_rvalid=0.

Reset
REQ-022 SHALL, on rst=0, asynchronously force state IDLE, starve_cnt=0, kill=0, dmem_addr/dmem_wdata/dmem_rmask/dmem_wmask=0, busy=0; ld_gnt/st_gnt/ld_rvalid/st_done=0 while rst=0.
REQ-023 SHALL, on reset mid-transaction, abandon it; a later dmem_resp in IDLE is ignored.

Verification
REQ-024 SHALL cover: ld_req, addr 0x100, rmask 0xF, resp 3 cycles later with rdata 0xDEADBEEF -> ld_gnt cycle 0, dmem_rmask=0xF cycle 1, ld_rvalid=1 and ld_rdata=0xDEADBEEF in resp cycle.
REQ-025 SHALL cover: ld_req and st_req continuously high, st_urgent=0, STARVE_LIMIT=8 -> 8 load grants then 1 store grant, pattern repeating.
REQ-026 SHALL cover: ld_req and st_req together, st_urgent=1 -> st_gnt first, dmem_wmask=st_wmask, st_done on resp, starve_cnt=0.
REQ-027 SHALL cover: flush one cycle after load grant -> dmem_rmask held until resp; ld_rvalid stays 0; FSM IDLE next cycle.
REQ-028 SHALL cover: store grant with st_wmask=0 -> no dmem activity, st_done=1 next cycle.
REQ-029 SHALL cover: rst=0 mid-STORE -> dmem_wmask=0 and busy=0 before next clock edge; later dmem_resp produces no st_done.
